cube: RTL and testbench
=======================

Name: cube

Overview:
- Sequential integer cube unit: computes y = x^3 for an unsigned WIDTH-bit operand.
- Inverse companion of the cube-root block, with the same start/busy/result handshake, so benches can round-trip cube -> cbrt.
- Built from two passes through one shift-add multiplier sub-module: first x*x, then (x*x)*x.
- Sits beside the cube-root block in the arithmetic datapath. One operation is in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits; result width is 3*WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request. Sampled on a rising clk edge, accepted only when busy=0.
- x_i  input  WIDTH  unsigned operand. Captured on the accepting edge only.
- result  output  3*WIDTH  x^3 of the last completed operation.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking the cycle in which result first shows a new value.

Behaviour:
- Reset values (rst=1 at a rising edge): state=IDLE, busy=0, done=0, result=0, internal operand/accumulator registers=0. Reset overrides everything, including start.
- States:
  - IDLE: busy=0.
  - SQ_LOAD: 1 cycle. Load multiplier with a=x_reg (2*WIDTH-bit multiplicand, zero-extended) and b=x_reg.
  - SQ_RUN: WIDTH cycles.
  - CU_LOAD: 1 cycle. a=square (zero-extended to 3*WIDTH), b=x_reg.
  - CU_RUN: WIDTH cycles.
  - Return to IDLE.
- Transitions:
  - IDLE & start -> SQ_LOAD. x_i is latched into x_reg on the same edge.
  - SQ_RUN -> CU_LOAD after the WIDTH-th step; the square (2*WIDTH bits) is latched.
  - CU_RUN -> IDLE after the WIDTH-th step; result <= product and done=1 for that one following cycle.
- Latency:
  - busy rises in the cycle after the accepting edge and stays high exactly 2*WIDTH+2 cycles (18 for WIDTH=8).
  - result and done update on the edge where busy falls.
- Multiplier step: each cycle, if b[0] then acc += a; then a <<= 1, b >>= 1.
  - acc is 3*WIDTH bits. The product is exact for all inputs, with no overflow or truncation: (2^WIDTH-1)^3 < 2^(3*WIDTH).
- result holds its value between operations. It is not cleared when a new operation starts.
- start while busy=1: ignored, with no effect on x_reg or the operation in flight. This includes the final busy cycle, so a new request is accepted no earlier than the first cycle with busy=0.
- x_i changing while busy: no effect.
- start held high continuously: back-to-back operations, each accepted on the first idle edge. There is exactly one idle cycle between operations.
- rst mid-operation: the operation is aborted, the next cycle is IDLE, and result returns to 0. No done pulse is emitted.
- x_i=0 and x_i=1: the full 2*WIDTH+2-cycle latency still applies. There is no early-exit path.

Decomposition:
- Shared include header (cube_defs) holds:
  - state encoding localparams: IDLE, SQ_LOAD, SQ_RUN, CU_LOAD, CU_RUN;
  - RES_W = 3*WIDTH;
  - step-counter width $clog2(WIDTH+1).
- Sub-module shift_add_mul (distinct from the existing combinational mul). Parameterised on A_W/B_W. Ports:
  - clk, rst, load, a_i, b_i;
  - acc_o, step_done.
- cube holds the FSM, x_reg, square register, step counter and result/done registers, and instantiates shift_add_mul once; both passes reuse it.

Test Plan:
- rst, then x_i=3, start for 1 cycle -> busy high for exactly 18 cycles, then result=27, done pulse of 1 cycle.
- x_i=6 -> result=216. x_i=255 -> result=16581375 (24'hFD02FF). Both with 18-cycle latency.
- x_i=0 -> result=0 after 18 cycles. Then x_i=1 -> result=1.
- Start x_i=4. Pulse start with x_i=9 while busy, including on the final busy cycle -> result=64, the second request is ignored, and busy is low for at least 1 cycle afterwards.
- Start x_i=5. Assert rst at busy cycle 10 -> next cycle busy=0, result=0, no done pulse. Then x_i=5 -> result=125.
- Hold start=1 with x_i=2, then 7 -> results 8 then 343, each 18 busy cycles separated by exactly 1 idle cycle. Cross-check: feeding 8 and 216 (results of x_i=2 and x_i=6) into the cube-root block returns 2 and 6.

Source files
------------

// File: rtl/cube_pkg.sv
// rtl/cube_pkg.sv - shared types and sizing helpers for the cube unit
//
// Purpose: FSM state encoding, default operand width and width helpers
//          shared by cube and shift_add_mul.
// Ports:   none (package).
package cube_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SQ_LOAD = 3'd1,
    SQ_RUN  = 3'd2,
    CU_LOAD = 3'd3,
    CU_RUN  = 3'd4
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Result width: (2^w-1)^3 always fits in 3*w bits.
  function automatic int res_width(input int w);
    return 3 * w;
  endfunction

  // Step counter must be able to count 0..w.
  function automatic int step_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/cube_shift_add_mul.sv
// rtl/cube_shift_add_mul.sv - sequential shift-add multiplier, one bit of b per cycle
//
// Purpose: acc = a * b computed over B_W cycles after a load cycle.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   load       capture a_i/b_i and clear the accumulator
//   a_i        multiplicand, A_W bits (must be wide enough for the product)
//   b_i        multiplier, B_W bits
//   acc_o      accumulator value including this cycle's step
//   step_done  high during the cycle that performs the final step
module shift_add_mul
  import cube_pkg::*;
#(
  parameter int A_W = 24,
  parameter int B_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [A_W-1:0] acc_o,
  output logic           step_done
);

  localparam int CNT_W = step_cnt_width(B_W);

  logic [A_W-1:0]   a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [A_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [A_W-1:0]   sum;
  logic             last_step;

  assign sum       = acc_q + (b_q[0] ? a_q : '0);
  assign last_step = run_q && (cnt_q == CNT_W'(B_W - 1));

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (load) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = sum;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_step) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // Expose the post-step value so the owner can capture the final product
  // on the same edge that performs the last step.
  assign acc_o     = run_q ? sum : acc_q;
  assign step_done = last_step;

endmodule

// File: rtl/cube.sv
// rtl/cube.sv - sequential integer cube unit, y = x^3 via two multiplier passes
//
// Purpose: start/busy/done handshake; pass 1 computes x*x, pass 2 (x*x)*x,
//          both on one shared shift_add_mul.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   request, accepted only while busy=0
//   x_i     unsigned operand, captured on the accepting edge
//   result  x^3 of the last completed operation (3*WIDTH bits)
//   busy    operation in progress
//   done    one-cycle pulse in the first cycle showing a new result
module cube
  import cube_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       x_i,
  output logic [3*WIDTH-1:0]     result,
  output logic                   busy,
  output logic                   done
);

  localparam int RES_W = res_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [2*WIDTH-1:0] square_q, square_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               done_q, done_d;

  logic               mul_load;
  logic [RES_W-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [RES_W-1:0]   mul_acc;
  logic               mul_step_done;

  shift_add_mul #(
    .A_W (RES_W),
    .B_W (WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load),
    .a_i       (mul_a),
    .b_i       (mul_b),
    .acc_o     (mul_acc),
    .step_done (mul_step_done)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      square_q <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      square_q <= square_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Next state and register updates
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    square_d = square_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SQ_LOAD;
          x_d     = x_i;
        end
      end
      SQ_LOAD: state_d = SQ_RUN;
      SQ_RUN: begin
        if (mul_step_done) begin
          state_d  = CU_LOAD;
          square_d = mul_acc[2*WIDTH-1:0];
        end
      end
      CU_LOAD: state_d = CU_RUN;
      CU_RUN: begin
        if (mul_step_done) begin
          state_d  = IDLE;
          result_d = mul_acc;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and multiplier controls
  always_comb begin
    busy     = (state_q != IDLE);
    mul_load = (state_q == SQ_LOAD) || (state_q == CU_LOAD);
    mul_b    = x_q;
    if (state_q == CU_LOAD) begin
      mul_a = {{(RES_W - 2*WIDTH){1'b0}}, square_q};
    end else begin
      mul_a = {{(RES_W - WIDTH){1'b0}}, x_q};
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_cube.sv
// tb/tb_cube.sv - self-checking bench for cube against an arithmetic model
module tb_cube;

  localparam int WIDTH = 8;
  localparam int LAT   = 2 * WIDTH + 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   x_i;
  logic [3*WIDTH-1:0] result;
  logic               busy;
  logic               done;

  int checks   = 0;
  int failures = 0;
  longint unsigned last_res = 0;

  always #5 clk = ~clk;

  cube #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x_i    (x_i),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned cube_ref(input longint unsigned v);
    return v * v * v;
  endfunction

  // Integer cube root, standing in for the companion cube-root block.
  function automatic longint unsigned icbrt(input longint unsigned y);
    longint unsigned r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= y) r++;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles from the current (first busy) cycle until busy falls.
  // noise: scribble start/x_i while busy; last_hit forces start=1 on the final busy cycle.
  task automatic count_busy(input bit noise, input bit last_hit, input bit keep_start,
                            output int n, output int dones);
    n = 0;
    dones = 0;
    while (busy && n < 100) begin
      if (done) dones++;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        x_i   = WIDTH'($urandom);
      end else if (!keep_start) begin
        start = 1'b0;
      end
      if (last_hit && n == LAT - 1) start = 1'b1;
      n++;
      tick();
    end
    if (!keep_start) start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] x,
                        input bit noise, input bit last_hit);
    int n, dones;
    longint unsigned exp_r = cube_ref(longint'(x));
    start = 1'b1;
    x_i   = x;
    tick();
    count_busy(noise, last_hit, 1'b0, n, dones);
    check({tag, "_latency"}, n, LAT);
    check({tag, "_early_done"}, dones, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_result"}, result, exp_r);
    last_res = exp_r;
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_hold"}, result, exp_r);
  endtask

  initial begin
    int n, dones;
    longint unsigned r8, r216;
    rst   = 1'b1;
    start = 1'b1;
    x_i   = 8'd77;
    repeat (3) tick();
    rst   = 1'b0;
    start = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);

    run_op("x3", 8'd3, 1'b0, 1'b0);
    run_op("x6", 8'd6, 1'b0, 1'b0);
    r216 = result;
    run_op("x255", 8'd255, 1'b0, 1'b0);
    run_op("x0", 8'd0, 1'b0, 1'b0);
    run_op("x1", 8'd1, 1'b0, 1'b0);
    run_op("busy_ignore", 8'd4, 1'b1, 1'b1);

    // Abort mid-operation: reset on the 10th busy cycle.
    start = 1'b1;
    x_i   = 8'd5;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_done", done, 0);
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (done || busy) dones++;
      tick();
    end
    check("abort_quiet", dones, 0);
    run_op("after_abort", 8'd5, 1'b0, 1'b0);

    // Start held high: back-to-back with exactly one idle cycle.
    start = 1'b1;
    x_i   = 8'd2;
    tick();
    count_busy(1'b0, 1'b0, 1'b1, n, dones);
    check("b2b_lat1", n, LAT);
    check("b2b_done1", done, 1);
    check("b2b_res1", result, cube_ref(2));
    r8  = result;
    x_i = 8'd7;
    tick();
    check("b2b_gap", busy, 1);
    count_busy(1'b0, 1'b0, 1'b0, n, dones);
    check("b2b_lat2", n, LAT);
    check("b2b_res2", result, cube_ref(7));
    check("cbrt_8", icbrt(r8), 2);
    check("cbrt_216", icbrt(r216), 6);
    tick();

    // Randomized operands, with random start/x_i noise while busy.
    for (int k = 0; k < 30; k++) begin
      logic [WIDTH-1:0] xr;
      xr = WIDTH'($urandom);
      run_op($sformatf("rand%0d", k), xr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check($sformatf("rand%0d_cbrt", k), icbrt(result), longint'(xr));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
